fb_lane_renderer: RTL
=====================

Name: fb_lane_renderer

Overview:
- Parametrised, pipelined successor to the falling-block mapper.
- Once per scanline, a sequential scan engine walks the note register and latches, for each track, the sprite row of the note block covering the current DrawY.
- During active video, a two-stage pixel pipeline decodes the lane from DrawX, reads the sprite ROM and emits a per-lane hit vector to the colour mapper.

Parameters:
- N_LANES, 8: on-screen lanes; lane N_LANES-1 is leftmost.
- N_TRACKS, 4: note tracks; N_LANES must be a multiple of N_TRACKS.
- NOTE_DEPTH, 360: rows per track in the note register.
- LANE_X0, 64: left x of leftmost lane.
- LANE_PITCH, 54: x spacing between adjacent lanes.
- SPLIT_GAP, 102: extra x added to every lane in the right half (lane index < N_LANES/2).
- BLK_W, 32: block width in pixels; must be ≤ ROM word width.
- BLK_H, 18: block height in rows.
- Y_LIMIT, 377: last DrawY on which blocks are drawn.
- ROM_BASE, 54: sprite ROM word address of block row 0.

Ports:
- Clk, in, 1: pixel clock.
- Reset, in, 1: synchronous, active-high.
- line_start, in, 1: one-cycle pulse at the start of each scanline; DrawY is already valid for the new line.
- DrawX, in, 10: current pixel x.
- DrawY, in, 10: current pixel y.
- n_reg, in, N_TRACKS×NOTE_DEPTH: note register; bit [t][r] set = note on track t at row r.
- track_en, in, N_TRACKS: per-track draw enable.
- rom_addr, out, 8: synchronous sprite ROM address.
- rom_data, in, 32: ROM word, valid 1 cycle after rom_addr.
- is_fb, out, N_LANES: one-hot lane hit for the pixel presented 2 cycles earlier.
- line_ready, out, 1: per-track row data valid for the current line.

Behaviour:
- Reset values: is_fb=0, line_ready=0, rom_addr=0. The scan FSM goes to IDLE and all per-track valid flags clear.
- Lane geometry:
  - x_i = LANE_X0 + (N_LANES-1-i)*LANE_PITCH, plus SPLIT_GAP when i < N_LANES/2.
  - Lane i reads track (i mod N_TRACKS).
  - Defaults give lane x positions 64, 118, 172, 226, 382, 436, 490, 544 for lanes 7..0.
- Scan FSM states: IDLE, SCAN, READY.
  - line_start in any state → SCAN with trk=0 and line_ready=0. A restart mid-scan discards partial results.
  - SCAN: one track per cycle. Window rows are r = DrawY-(BLK_H-1) .. DrawY, clipped to r ≥ 0. Rows r ≥ NOTE_DEPTH read as 0.
  - Highest set r in the window wins (covers overlapping notes). row[trk] = BLK_H-1-(DrawY-r); valid[trk] = any bit set AND track_en[trk] AND DrawY ≤ Y_LIMIT.
  - After trk = N_TRACKS-1 → READY; line_ready=1 from the next cycle. Scan latency is exactly N_TRACKS cycles after line_start.
  - READY holds until the next line_start.
- Pixel pipeline, 2-cycle latency:
  - S1 (registered): find the lane with x_i ≤ DrawX < x_i+BLK_W. Lanes never overlap, so at most one matches.
  - S1 drives rom_addr = ROM_BASE + row[track(lane)] when that track is valid and line_ready=1; otherwise rom_addr=0. It also registers lane, lane hit and xoff = DrawX - x_lane.
  - S2: is_fb[lane] = lane_hit AND rom_data[31-xoff]; all other bits 0.
- Boundaries:
  - DrawY < BLK_H-1: window is truncated at row 0 with no wrap.
  - DrawY > Y_LIMIT: all tracks invalid.
  - No lane matches: is_fb=0.
  - line_ready=0: is_fb=0.
  - Reset mid-line: outputs are 0 until a line_start-triggered scan completes.
- Width rules: row is 5 bits; rom_addr sum is 8 bits unsigned; xoff is 5 bits; DrawY-r is computed in 11-bit signed arithmetic.

Decomposition:
- Package fb_pkg: parameter defaults, the row_t (5b) typedef, and the scan_state_t enum {IDLE, SCAN, READY}.
- Sub-module fb_track_scan: the windowed priority search for one track, instantiated once and time-multiplexed by the FSM.
- The lane x positions are computed as a localparam array in the top level.

Test Plan:
- Reset asserted mid-SCAN → is_fb=0, line_ready=0. A later line_start gives line_ready=1 exactly 4 cycles after the pulse.
- n_reg[3][100]=1, DrawY=110, DrawX=64..95 → rom_addr=54+7=61 at cycle 1. is_fb=8'h80 two cycles after each DrawX where ROM bit 31-xoff=1.
- Overlapping notes n_reg[0][100] and n_reg[0][105], DrawY=110 → row=12 (row 105 wins). Lanes 4 (x 226) and 0 (x 544) both draw, giving is_fb=8'h10 and 8'h01 respectively.
- DrawY=5 with n_reg[1][0]=1 → row=12, no wrap to high rows. DrawY=378 with notes present → is_fb=0.
- track_en=4'b1101 with notes on all tracks → lanes 5 and 1 (x 172 and 490) are never set.
- line_start pulsed twice 2 cycles apart → the scan restarts and line_ready rises 4 cycles after the second pulse.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared defaults and types for the falling-block lane renderer.
// Holds the geometry defaults, the sprite row type and the scan FSM encoding.
package fb_pkg;

    localparam int DEF_N_LANES    = 8;
    localparam int DEF_N_TRACKS   = 4;
    localparam int DEF_NOTE_DEPTH = 360;
    localparam int DEF_LANE_X0    = 64;
    localparam int DEF_LANE_PITCH = 54;
    localparam int DEF_SPLIT_GAP  = 102;
    localparam int DEF_BLK_W      = 32;
    localparam int DEF_BLK_H      = 18;
    localparam int DEF_Y_LIMIT    = 377;
    localparam int DEF_ROM_BASE   = 54;

    typedef logic [4:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        READY = 2'd2
    } scan_state_t;

endpackage

// File: rtl/fb_track_scan.sv
// Windowed priority search over one track's note column.
// Reports whether any note covers draw_y and the sprite row of the lowest-on-screen one.
module fb_track_scan
    import fb_pkg::*;
#(
    parameter int NOTE_DEPTH = DEF_NOTE_DEPTH,
    parameter int BLK_H      = DEF_BLK_H
) (
    input  logic [NOTE_DEPTH-1:0] notes,
    input  logic [9:0]            draw_y,
    output logic                  hit,
    output row_t                  row
);

    localparam int                IW      = $clog2(NOTE_DEPTH);
    localparam logic signed [10:0] DEPTH_S = 11'(NOTE_DEPTH);

    logic [BLK_H-1:0] in_win_s;

    // Bit k flags a set note at row draw_y-k; negative rows and rows past the register read as empty.
    always_comb begin
        logic signed [10:0] r_s;
        r_s      = '0;
        in_win_s = '0;
        for (int k = 0; k < BLK_H; k++) begin
            r_s         = $signed({1'b0, draw_y}) - $signed(11'(k));
            in_win_s[k] = (r_s >= 11'sd0) && (r_s < DEPTH_S) && notes[r_s[IW-1:0]];
        end
    end

    // Smallest offset (highest row) wins, so it is applied last.
    always_comb begin
        hit = |in_win_s;
        row = '0;
        for (int k = BLK_H - 1; k >= 0; k--) begin
            row = in_win_s[k] ? row_t'(BLK_H - 1 - k) : row;
        end
    end

endmodule

// File: rtl/fb_lane_renderer.sv
// Pipelined falling-block renderer: per-line track scan plus a two-stage pixel
// pipeline that turns DrawX into a one-hot lane hit using a synchronous sprite ROM.
module fb_lane_renderer
    import fb_pkg::*;
#(
    parameter int N_LANES    = DEF_N_LANES,
    parameter int N_TRACKS   = DEF_N_TRACKS,
    parameter int NOTE_DEPTH = DEF_NOTE_DEPTH,
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH,
    parameter int SPLIT_GAP  = DEF_SPLIT_GAP,
    parameter int BLK_W      = DEF_BLK_W,
    parameter int BLK_H      = DEF_BLK_H,
    parameter int Y_LIMIT    = DEF_Y_LIMIT,
    parameter int ROM_BASE   = DEF_ROM_BASE
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 line_start,
    input  logic [9:0]                           DrawX,
    input  logic [9:0]                           DrawY,
    input  logic [N_TRACKS-1:0][NOTE_DEPTH-1:0]  n_reg,
    input  logic [N_TRACKS-1:0]                  track_en,
    output logic [7:0]                           rom_addr,
    input  logic [31:0]                          rom_data,
    output logic [N_LANES-1:0]                   is_fb,
    output logic                                 line_ready
);

    localparam int TW = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1;
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef logic [N_LANES-1:0][10:0] lane_x_t;

    function automatic lane_x_t calc_lane_x();
        lane_x_t x;
        for (int i = 0; i < N_LANES; i++) begin
            x[i] = 11'(LANE_X0 + (N_LANES - 1 - i) * LANE_PITCH
                       + ((i < N_LANES / 2) ? SPLIT_GAP : 0));
        end
        return x;
    endfunction

    localparam lane_x_t LANE_X = calc_lane_x();

    scan_state_t           state_r;
    logic [TW-1:0]         trk_r;
    row_t                  row_r [N_TRACKS];
    logic [N_TRACKS-1:0]   valid_r;
    logic                  line_ready_r;

    logic                  scan_hit_s;
    row_t                  scan_row_s;
    logic                  y_ok_s;

    fb_track_scan #(
        .NOTE_DEPTH (NOTE_DEPTH),
        .BLK_H      (BLK_H)
    ) u_scan (
        .notes  (n_reg[trk_r]),
        .draw_y (DrawY),
        .hit    (scan_hit_s),
        .row    (scan_row_s)
    );

    assign y_ok_s = (DrawY <= 10'(Y_LIMIT));

    // Scan FSM: one track per cycle after line_start, then hold results until the next line.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= IDLE;
            trk_r        <= '0;
            valid_r      <= '0;
            line_ready_r <= 1'b0;
            for (int t = 0; t < N_TRACKS; t++) begin
                row_r[t] <= '0;
            end
        end else if (line_start) begin
            state_r      <= SCAN;
            trk_r        <= '0;
            valid_r      <= '0;
            line_ready_r <= 1'b0;
        end else begin
            case (state_r)
                SCAN: begin
                    row_r[trk_r]   <= scan_row_s;
                    valid_r[trk_r] <= scan_hit_s && track_en[trk_r] && y_ok_s;
                    if (trk_r == TW'(N_TRACKS - 1)) begin
                        state_r      <= READY;
                        line_ready_r <= 1'b1;
                    end else begin
                        trk_r <= trk_r + 1'b1;
                    end
                end
                IDLE, READY: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r      <= IDLE;
                    line_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign line_ready = line_ready_r;

    logic [N_LANES-1:0] lane_hit_s;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign lane_hit_s[i] = ({1'b0, DrawX} >= LANE_X[i])
                            && ({1'b0, DrawX} < LANE_X[i] + 11'(BLK_W));
    end

    logic          match_s;
    logic [LW-1:0] lane_s;
    logic [4:0]    xoff_s;
    logic [TW-1:0] lane_trk_s;
    logic          draw_ok_s;

    // Lanes never overlap, so at most one lane_hit_s bit is set.
    always_comb begin
        match_s = |lane_hit_s;
        lane_s  = '0;
        xoff_s  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_s = lane_hit_s[i] ? LW'(i) : lane_s;
            xoff_s = lane_hit_s[i] ? 5'({1'b0, DrawX} - LANE_X[i]) : xoff_s;
        end
        lane_trk_s = TW'(int'(lane_s) % N_TRACKS);
        draw_ok_s  = match_s && line_ready_r && valid_r[lane_trk_s];
    end

    logic [7:0]    rom_addr_r;
    logic [LW-1:0] lane1_r, lane2_r;
    logic          hit1_r, hit2_r;
    logic [4:0]    xoff1_r, xoff2_r;

    // S1: issue the ROM read and capture the lane context of this pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_r <= 8'd0;
            lane1_r    <= '0;
            hit1_r     <= 1'b0;
            xoff1_r    <= 5'd0;
        end else begin
            if (draw_ok_s) begin
                rom_addr_r <= 8'(ROM_BASE) + 8'(row_r[lane_trk_s]);
            end else begin
                rom_addr_r <= 8'd0;
            end
            lane1_r <= lane_s;
            hit1_r  <= draw_ok_s;
            xoff1_r <= xoff_s;
        end
    end

    // S2: lane context travels alongside the ROM's own output register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lane2_r <= '0;
            hit2_r  <= 1'b0;
            xoff2_r <= 5'd0;
        end else begin
            lane2_r <= lane1_r;
            hit2_r  <= hit1_r;
            xoff2_r <= xoff1_r;
        end
    end

    assign rom_addr = rom_addr_r;

    // Final bit-select lines up with rom_data, which is already registered inside the ROM.
    always_comb begin
        is_fb          = '0;
        is_fb[lane2_r] = hit2_r & rom_data[5'd31 - xoff2_r];
    end

endmodule
